l2cache_tagv_array: RTL and testbench

L2CACHE_TAGV_ARRAY -- requirements
Module: l2cache_tagv_array

---
 rtl/l2cache_tagv_array_pkg.sv | 19 +
 rtl/l2cache_tagv_array_bram.sv | 26 ++
 rtl/l2cache_tagv_array.sv | 177 +++++++++++++++++
 tb/tb_l2cache_tagv_array.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2cache_tagv_array_pkg.sv
// Shared L2 cache definitions: sweep FSM encoding and way-index width derivation.
package l2cache_tagv_array_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    // Bits needed to index 'ways' ways (at least 1).
    function automatic int unsigned way_bits(input int unsigned ways);
        int unsigned b;
        b = 1;
        while ((32'd1 << b) < ways) begin
            b++;
        end
        return b;
    endfunction

endpackage

// File: rtl/l2cache_tagv_array_bram.sv
// Simple dual-port RAM, one write and one registered read port, read-first.
module l2cache_tagv_array_bram #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 25
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    // Write port plus registered read of the pre-write contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/l2cache_tagv_array.sv
// L2 cache tag/valid array: per-way tag RAMs, valid flops, hit logic and flush sweep.
module l2cache_tagv_array
    import l2cache_tagv_array_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 4,
    parameter  int unsigned TAG_WIDTH  = 25,
    parameter  int unsigned WAY        = 4,
    localparam int unsigned WAY_BITS   = way_bits(WAY)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush_req,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [TAG_WIDTH-1:0]  cmp_tag,
    input  logic [WAY_BITS-1:0]   way_sel,
    output logic [TAG_WIDTH-1:0]  tag_dout,
    output logic [WAY-1:0]        valid,
    output logic [WAY-1:0]        hit,
    output logic                  hit_any,
    output logic [WAY_BITS-1:0]   hit_idx,
    output logic                  multi_hit,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic [WAY-1:0]        wr_we,
    input  logic [WAY-1:0]        wr_inv
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    sweep_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  sweeping;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic [WAY-1:0]        vld_we, vld_wval, tag_we;
    logic                  same_set;

    logic [DEPTH-1:0]      vld_q [WAY];
    logic [WAY-1:0]        rd_vld_q;
    logic [WAY-1:0]        byp_sel_q;
    logic [TAG_WIDTH-1:0]  byp_tag_q [WAY];
    logic [TAG_WIDTH-1:0]  bram_dout [WAY];
    logic [TAG_WIDTH-1:0]  tag_out [WAY];

    assign sweeping = (state_q == ST_SWEEP);
    assign busy     = sweeping;
    assign same_set = (w_addr == rd_addr);

    // Sweep FSM state and set counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep FSM next state: one set cleared per cycle, counter wraps to 0 on exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    // Write port mux: sweep clears whole sets, otherwise invalidate wins over write.
    always_comb begin
        w_addr   = sweeping ? cnt_q : wr_addr;
        w_tag    = sweeping ? '0 : wr_tag;
        vld_we   = '0;
        vld_wval = '0;
        tag_we   = '0;
        if (rstn) begin
            if (sweeping) begin
                vld_we = '1;
                tag_we = '1;
            end else begin
                vld_we   = wr_we | wr_inv;
                vld_wval = wr_we & ~wr_inv;
                tag_we   = wr_we & ~wr_inv;
            end
        end
    end

    // Valid bit storage, one flop vector per way.
    always_ff @(posedge clk) begin
        for (int w = 0; w < int'(WAY); w++) begin
            if (vld_we[w]) begin
                vld_q[w][w_addr] <= vld_wval[w];
            end
        end
    end

    // Registered read of valid plus tag bypass so a same-set write is seen immediately.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_vld_q  <= '0;
            byp_sel_q <= '1;
            for (int w = 0; w < int'(WAY); w++) begin
                byp_tag_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < int'(WAY); w++) begin
                rd_vld_q[w]  <= (vld_we[w] && same_set) ? vld_wval[w] : vld_q[w][rd_addr];
                byp_sel_q[w] <= tag_we[w] && same_set;
                byp_tag_q[w] <= w_tag;
            end
        end
    end

    // Tag storage, one RAM per way.
    for (genvar g = 0; g < int'(WAY); g++) begin : g_way
        l2cache_tagv_array_bram #(
            .AW (ADDR_WIDTH),
            .DW (TAG_WIDTH)
        ) u_bram (
            .clk     (clk),
            .we_i    (tag_we[g]),
            .waddr_i (w_addr),
            .wdata_i (w_tag),
            .raddr_i (rd_addr),
            .rdata_o (bram_dout[g])
        );
    end

    // Read data selection, hit detection and priority encode.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        valid     = sweeping ? '0 : rd_vld_q;
        hit       = '0;
        hit_idx   = '0;
        multi_hit = 1'b0;
        for (int w = 0; w < int'(WAY); w++) begin
            tag_out[w] = byp_sel_q[w] ? byp_tag_q[w] : bram_dout[w];
            hit[w]     = valid[w] && (tag_out[w] == cmp_tag);
        end
        for (int w = int'(WAY) - 1; w >= 0; w--) begin
            if (hit[w]) begin
                hit_idx = WAY_BITS'(w);
            end
        end
        for (int w = 0; w < int'(WAY); w++) begin
            if (hit[w]) begin
                if (seen) begin
                    multi_hit = 1'b1;
                end
                seen = 1'b1;
            end
        end
        hit_any  = |hit;
        tag_dout = tag_out[way_sel];
    end

endmodule

// File: tb/tb_l2cache_tagv_array.sv
// Bench for l2cache_tagv_array: directed vector table, flush sequence, random vs. model.
module tb_l2cache_tagv_array;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush_req;
    logic        busy;
    logic [3:0]  rd_addr;
    logic [24:0] cmp_tag;
    logic [1:0]  way_sel;
    logic [24:0] tag_dout;
    logic [3:0]  valid;
    logic [3:0]  hit;
    logic        hit_any;
    logic [1:0]  hit_idx;
    logic        multi_hit;
    logic [3:0]  wr_addr;
    logic [24:0] wr_tag;
    logic [3:0]  wr_we;
    logic [3:0]  wr_inv;

    l2cache_tagv_array dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush_req (flush_req),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .cmp_tag   (cmp_tag),
        .way_sel   (way_sel),
        .tag_dout  (tag_dout),
        .valid     (valid),
        .hit       (hit),
        .hit_any   (hit_any),
        .hit_idx   (hit_idx),
        .multi_hit (multi_hit),
        .wr_addr   (wr_addr),
        .wr_tag    (wr_tag),
        .wr_we     (wr_we),
        .wr_inv    (wr_inv)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: the cache contents as plain arrays, sweep as a cycles-left count.
    bit   [3:0]  m_vld [16];
    logic [24:0] m_tag [16][4];
    bit   [3:0]  m_rd_vld;
    logic [24:0] m_rd_tag [4];
    int          m_left = 0;

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  wa;
        logic [24:0] wt;
        logic [3:0]  we;
        logic [3:0]  inv;
        logic [24:0] cmp;
        logic [1:0]  ws;
        logic [3:0]  ev;
        logic [3:0]  eh;
        logic [1:0]  ei;
        logic        em;
        logic [24:0] et;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int s;
        if (!rstn) begin
            m_left   = 16;
            m_rd_vld = '0;
            for (int w = 0; w < 4; w++) m_rd_tag[w] = '0;
        end else begin
            if (m_left > 0) begin
                s        = 16 - m_left;
                m_vld[s] = '0;
                for (int w = 0; w < 4; w++) m_tag[s][w] = '0;
                m_left--;
            end else begin
                for (int w = 0; w < 4; w++) begin
                    if (wr_inv[w]) begin
                        m_vld[wr_addr][w] = 1'b0;
                    end else if (wr_we[w]) begin
                        m_vld[wr_addr][w] = 1'b1;
                        m_tag[wr_addr][w] = wr_tag;
                    end
                end
                if (flush_req) m_left = 16;
            end
            m_rd_vld = m_vld[rd_addr];
            for (int w = 0; w < 4; w++) m_rd_tag[w] = m_tag[rd_addr][w];
        end
    endtask

    task automatic check_model();
        logic [3:0] ev, eh;
        logic [1:0] ei;
        int         nh;
        ev = (m_left > 0) ? 4'b0000 : m_rd_vld;
        eh = '0;
        for (int w = 0; w < 4; w++) if (ev[w] && (m_rd_tag[w] == cmp_tag)) eh[w] = 1'b1;
        nh = 0;
        ei = '0;
        for (int w = 3; w >= 0; w--) begin
            if (eh[w]) begin
                ei = 2'(w);
                nh++;
            end
        end
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("valid", 32'(valid), 32'(ev));
        chk("hit", 32'(hit), 32'(eh));
        chk("hit_any", 32'(hit_any), 32'(eh != 4'b0000));
        chk("hit_idx", 32'(hit_idx), 32'(ei));
        chk("multi_hit", 32'(multi_hit), 32'(nh > 1));
        if (m_left == 0) chk("tag_dout", 32'(tag_dout), 32'(m_rd_tag[way_sel]));
    endtask

    // One clock: model update, edge, then present compare inputs and check.
    task automatic tick(input logic [24:0] ctag, input logic [1:0] wsel);
        model_step();
        @(posedge clk);
        #1;
        cmp_tag = ctag;
        way_sel = wsel;
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        flush_req = 1'b0;
        wr_we     = '0;
        wr_inv    = '0;
        wr_addr   = '0;
        wr_tag    = '0;
    endtask

    initial begin
        int n;
        for (int s = 0; s < 16; s++) begin
            m_vld[s] = '0;
            for (int w = 0; w < 4; w++) m_tag[s][w] = '0;
        end
        rstn    = 1'b0;
        rd_addr = '0;
        cmp_tag = '0;
        way_sel = '0;
        idle_inputs();

        vecs[0] = '{4'd5, 4'd3, 25'h1ABC, 4'b0100, 4'b0000, 25'h0,    2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 25'h0};
        vecs[1] = '{4'd3, 4'd0, 25'h0,    4'b0000, 4'b0000, 25'h1ABC, 2'd2, 4'b0100, 4'b0100, 2'd2, 1'b0, 25'h1ABC};
        vecs[2] = '{4'd7, 4'd7, 25'h55,   4'b0001, 4'b0000, 25'h55,   2'd0, 4'b0001, 4'b0001, 2'd0, 1'b0, 25'h55};
        vecs[3] = '{4'd0, 4'd9, 25'h123,  4'b1111, 4'b1000, 25'h0,    2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 25'h0};
        vecs[4] = '{4'd9, 4'd0, 25'h0,    4'b0000, 4'b0000, 25'h123,  2'd3, 4'b0111, 4'b0111, 2'd0, 1'b1, 25'h0};
        vecs[5] = '{4'd2, 4'd2, 25'h77,   4'b0011, 4'b0000, 25'h77,   2'd1, 4'b0011, 4'b0011, 2'd0, 1'b1, 25'h77};
        vecs[6] = '{4'd2, 4'd0, 25'h0,    4'b0000, 4'b0000, 25'h78,   2'd1, 4'b0011, 4'b0000, 2'd0, 1'b0, 25'h77};
        vecs[7] = '{4'd2, 4'd2, 25'h0,    4'b0000, 4'b0001, 25'h77,   2'd0, 4'b0010, 4'b0010, 2'd1, 1'b0, 25'h77};
        vecs[8] = '{4'd3, 4'd0, 25'h0,    4'b0000, 4'b0000, 25'h1ABC, 2'd3, 4'b0100, 4'b0100, 2'd2, 1'b0, 25'h0};

        // Reset, then count the post-reset sweep.
        tick('0, '0);
        tick('0, '0);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_valid", 32'(valid), 32'd0);
        rstn = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick('0, '0);
        end
        chk("reset_sweep_cycles", 32'(n), 32'd16);

        // Directed vectors.
        for (int i = 0; i < 9; i++) begin
            rd_addr = vecs[i].rd;
            wr_addr = vecs[i].wa;
            wr_tag  = vecs[i].wt;
            wr_we   = vecs[i].we;
            wr_inv  = vecs[i].inv;
            tick(vecs[i].cmp, vecs[i].ws);
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].eh));
            chk($sformatf("vec%0d_hit_idx", i), 32'(hit_idx), 32'(vecs[i].ei));
            chk($sformatf("vec%0d_multi_hit", i), 32'(multi_hit), 32'(vecs[i].em));
            chk($sformatf("vec%0d_tag_dout", i), 32'(tag_dout), 32'(vecs[i].et));
            idle_inputs();
        end

        // Flush with a second flush request and writes during the sweep.
        flush_req = 1'b1;
        tick('0, '0);
        flush_req = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 4 || n == 15) begin
                flush_req = 1'b1;
                wr_we     = 4'b1111;
                wr_addr   = 4'(n);
                wr_tag    = 25'h3F;
            end
            tick('0, '0);
            idle_inputs();
        end
        chk("flush_sweep_cycles", 32'(n), 32'd16);
        for (int s = 0; s < 16; s++) begin
            rd_addr = 4'(s);
            tick('0, '0);
            chk($sformatf("post_flush_valid_set%0d", s), 32'(valid), 32'd0);
        end

        // Random traffic, occasional flush and reset, checked against the model.
        for (int i = 0; i < 1500; i++) begin
            rstn      = ($urandom_range(0, 299) != 0);
            flush_req = ($urandom_range(0, 79) == 0);
            rd_addr   = 4'($urandom_range(0, 15));
            wr_addr   = ($urandom_range(0, 1) == 0) ? rd_addr : 4'($urandom_range(0, 15));
            wr_tag    = 25'($urandom_range(0, 7));
            wr_we     = 4'($urandom_range(0, 15));
            wr_inv    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            tick(25'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
